// File: rtl/sram_controller.sv
// Bridges a 32-bit load/store request onto a 16-bit asynchronous SRAM as two
// halfword accesses (low half first), stalling the pipeline through `ready`.
module sram_controller #(
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    input  logic [15:0] sram_dq_in,
    output logic        sram_dq_oe,
    output logic        sram_we_n,
    output logic        sram_oe_n,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        op_wr_q, op_wr_d;
    logic [16:0] idx_q, idx_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;

    logic        req;
    logic        last;
    logic [16:0] idx_in;

    assign req    = rd_en | wr_en;
    assign last   = (cnt_q == LAST);
    assign idx_in = 17'((address - 32'(BASE_ADDR)) >> 2);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_wr_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_wr_q <= op_wr_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Read data is captured on the last cycle of each phase, when the bus has settled longest.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_wr_d = op_wr_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                    op_wr_d = wr_en;
                    idx_d   = idx_in;
                    wdata_d = write_data;
                end
            end
            S_LOW: begin
                if (last) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                    if (!op_wr_q) rdata_d[15:0] = sram_dq_in;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_HIGH: begin
                if (last) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                    if (!op_wr_q) rdata_d[31:16] = sram_dq_in;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes come only from registered state; we_n rises on the last phase cycle
    // so the data is still driven across the rising edge.
    always_comb begin
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        sram_oe_n   = 1'b1;
        if (state_q == S_LOW || state_q == S_HIGH) begin
            sram_addr = {idx_q, state_q == S_HIGH};
            if (op_wr_q) begin
                sram_dq_oe  = 1'b1;
                sram_dq_out = (state_q == S_HIGH) ? wdata_q[31:16] : wdata_q[15:0];
                sram_we_n   = last;
            end else begin
                sram_oe_n = 1'b0;
            end
        end
    end

    assign ready     = rst | (state_q == S_DONE) | ((state_q == S_IDLE) & ~req);
    assign read_data = rdata_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_sram_controller.sv
// Randomized bench for sram_controller: a halfword SRAM model on the bus and a
// word-level reference memory predicting every access, cycle by cycle.
module tb_sram_controller;

    localparam int W    = 3;
    localparam int BASE = 1024;

    logic        clk;
    logic        rst;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic [15:0] sram_dq_in;
    logic        sram_dq_oe;
    logic        sram_we_n;
    logic        sram_oe_n;
    logic [1:0]  dbg_state;

    int n_vec;
    int n_err;

    logic [15:0] sram_mem [0:255];
    logic [31:0] ref_mem  [0:127];
    logic [31:0] prev_rd;

    sram_controller #(.BASE_ADDR(BASE), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en),
        .address(address), .write_data(write_data), .read_data(read_data),
        .ready(ready), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
        .sram_dq_in(sram_dq_in), .sram_dq_oe(sram_dq_oe),
        .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n), .dbg_state(dbg_state)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // asynchronous SRAM model: drives the bus while OE is low, stores while WE is low
    assign sram_dq_in = sram_oe_n ? 16'h0000 : sram_mem[sram_addr[7:0]];
    always @(posedge clk) begin
        if (!sram_we_n && sram_dq_oe) sram_mem[sram_addr[7:0]] = sram_dq_out;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One access starting in IDLE, #1 after a rising edge; returns the same way.
    // drop_at withdraws the request at that cycle, abort_at asserts rst there.
    task automatic do_access(input logic wr, input logic rd, input logic [31:0] addr,
                             input logic [31:0] data, input int drop_at, input int abort_at);
        int          idx;
        logic        active;
        logic        high;
        int          c;
        logic [17:0] e_addr;
        logic [15:0] e_dq;
        logic [31:0] e_rd;
        logic [37:0] got_o;
        logic [37:0] exp_o;
        idx        = int'((addr - 32'(BASE)) >> 2) & 'h1ffff;
        rd_en      = rd;
        wr_en      = wr;
        address    = addr;
        write_data = data;
        for (int k = 0; k <= 2 * W + 1; k++) begin
            if (k == drop_at) begin
                rd_en = 1'b0;
                wr_en = 1'b0;
            end
            @(negedge clk);
            active = (k >= 1) && (k <= 2 * W);
            high   = (k > W);
            c      = high ? k - W - 1 : k - 1;
            e_addr = active ? 18'(idx * 2 + (high ? 1 : 0)) : 18'd0;
            e_dq   = (active && wr) ? (high ? data[31:16] : data[15:0]) : 16'h0000;
            exp_o  = {k == 2 * W + 1, e_addr, !(active && wr && c < W - 1),
                      !(active && !wr), active && wr, e_dq};
            got_o  = {ready, sram_addr, sram_we_n, sram_oe_n, sram_dq_oe, sram_dq_out};
            check("outs", 64'(got_o), 64'(exp_o));
            if (k == 2 * W + 1) begin
                e_rd = wr ? prev_rd : ref_mem[idx];
                check("rdata", 64'(read_data), 64'(e_rd));
                prev_rd = e_rd;
                if (wr) ref_mem[idx] = data;
            end
            if (k == abort_at) begin
                rst = 1'b1;
                @(posedge clk);
                @(negedge clk);
                exp_o = {1'b1, 18'd0, 1'b1, 1'b1, 1'b0, 16'h0000};
                got_o = {ready, sram_addr, sram_we_n, sram_oe_n, sram_dq_oe, sram_dq_out};
                check("abort_outs", 64'(got_o), 64'(exp_o));
                check("abort_rdata", 64'(read_data), 64'd0);
                prev_rd = '0;
                rst     = 1'b0;
                rd_en   = 1'b0;
                wr_en   = 1'b0;
                for (int j = 0; j < 2 * W + 2; j++) begin
                    @(negedge clk);
                    check("abort_no_we", 64'(sram_we_n), 64'd1);
                end
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
        end
        rd_en = 1'b0;
        wr_en = 1'b0;
    endtask

    // stimulus and final report
    initial begin
        int          op;
        int          idx;
        int          drop;
        logic [31:0] addr;
        n_vec      = 0;
        n_err      = 0;
        prev_rd    = '0;
        for (int i = 0; i < 256; i++) sram_mem[i] = 16'($urandom);
        sram_mem[0] = 16'h5678;
        sram_mem[1] = 16'h1234;
        for (int i = 0; i < 128; i++) ref_mem[i] = {sram_mem[2 * i + 1], sram_mem[2 * i]};

        rst        = 1'b1;
        rd_en      = 1'b1;
        wr_en      = 1'b0;
        address    = 32'd1024;
        write_data = '0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_outs", 64'({ready, sram_addr, sram_we_n, sram_oe_n, sram_dq_oe, sram_dq_out}),
                  64'({1'b1, 18'd0, 1'b1, 1'b1, 1'b0, 16'h0000}));
            check("rst_rdata", 64'(read_data), 64'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;

        do_access(1'b0, 1'b1, 32'd1024, 32'h0, -1, -1);
        check("read_word", 64'(read_data), 64'h12345678);
        do_access(1'b1, 1'b0, 32'd1032, 32'hDEADBEEF, -1, -1);
        do_access(1'b0, 1'b1, 32'd1032, 32'h0, -1, -1);
        check("b2b_word", 64'(read_data), 64'hDEADBEEF);
        do_access(1'b1, 1'b1, 32'd1040, 32'hCAFEF00D, -1, -1);
        do_access(1'b0, 1'b1, 32'd1040, 32'h0, -1, -1);
        do_access(1'b0, 1'b1, 32'd1044, 32'h0, 2, -1);
        do_access(1'b1, 1'b0, 32'(BASE + 400), 32'hA5A55A5A, -1, W + 1);
        do_access(1'b0, 1'b1, 32'd1048, 32'h0, -1, -1);

        for (int t = 0; t < 40; t++) begin
            op   = int'($urandom_range(0, 2));
            idx  = int'($urandom_range(0, 63));
            addr = 32'(BASE + idx * 4) + 32'($urandom_range(0, 3));
            drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2 * W)) : -1;
            do_access(op != 0, op != 1, addr, $urandom, drop, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
